pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline inter-stage register with a valid/ready handshake and a one-entry skid buffer.
- Generalises the plain enable register and the stall-gated PC register:
  - configurable width and reset value;
  - backpressure without a combinational ready path;
  - synchronous flush for branch and exception squash.
- Sits between pipeline stages (IF/ID, ID/EX, ...). Full throughput, 1-cycle latency.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, 0 (WIDTH bits), value loaded into both data registers on reset.
- CNT_WIDTH, 16, width of the stall counter (used only when PIPE_SKID_STALL_CNT_EN is defined).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has data.
- in_ready  out  1  register can accept; driven directly from a flop.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  output holds valid data.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  output payload; driven directly from the main data register.
- stall_cnt  out  CNT_WIDTH  saturating backpressure counter; port exists only with PIPE_SKID_STALL_CNT_EN.

Behaviour:
- Transfer definitions:
  - input transfer: in_valid & in_ready at a rising edge;
  - output transfer: out_valid & out_ready at a rising edge.
- Storage: main register (main_data, main_v) and skid register (skid_data, skid_v).
  - out_valid = main_v; out_data = main_data; in_ready = !skid_v.
- State is encoded by {skid_v, main_v}: EMPTY = 00, BUSY = 01, FULL = 11. The value 10 is illegal and unreachable.
- Reset (rst=1, asynchronous):
  - state EMPTY; main_data = skid_data = RESET_VALUE;
  - out_valid=0, in_ready=1, stall_cnt=0.
  - Applies immediately, mid-transfer included. No handshake completes in a cycle where rst is high.
- Transitions (flush=0):
  - EMPTY: input transfer -> main<=in_data, go to BUSY. Otherwise hold.
  - BUSY, input and output transfer together -> main<=in_data, stay BUSY.
  - BUSY, input only (out_ready=0) -> skid<=in_data, go to FULL. main is unchanged.
  - BUSY, output only -> go to EMPTY. main_data is retained but invalid.
  - BUSY, neither -> hold.
  - FULL: in_ready=0, so no input transfer is possible.
    - Output transfer -> main<=skid, skid_v=0, go to BUSY.
    - Otherwise hold.
- Ordering: data leaves in the order it was accepted. No drop and no duplication under any valid/ready pattern.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N (when the register was EMPTY, or BUSY with a simultaneous output transfer).
- Throughput: one word per cycle sustained while out_ready=1.
- in_ready never depends combinationally on out_ready.
- Flush (flush=1 at an edge):
  - main_v=0, skid_v=0, go to EMPTY;
  - an input transfer in that cycle is discarded;
  - an output transfer in that cycle counts as completed (downstream has already sampled it);
  - data registers are not cleared;
  - in_ready=1 from the next cycle.
- Priority: rst > flush > normal transitions.
- Data registers update only on the writes listed above. Stall cycles must not corrupt out_data.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 at each edge where out_valid=1 and out_ready=0;
  - saturates at all-ones;
  - cleared only by rst; flush does not clear it.
- Undefined: the stall_cnt port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, in_valid=1, in_data=0x00000011, out_ready=1 -> after one edge out_valid=1, out_data=0x11. During reset out_data=0x00000000 and in_ready=1.
- Stream of 0x1, 0x2, 0x3, 0x4 on consecutive cycles with out_ready=1 -> outputs 0x1..0x4 on consecutive cycles with no bubbles; in_ready stays 1 throughout.
- Send 0xA then 0xB while out_ready=0 ->
  - state FULL, in_ready=0, out_data=0xA held;
  - 0xC is held off upstream;
  - raising out_ready yields 0xA, 0xB, 0xC in order.
- FULL with 0xA/0xB, assert flush for one cycle with in_valid=1, in_data=0xD ->
  - next cycle out_valid=0, in_ready=1;
  - 0xD is never output; the following input 0xE is output normally.
- Assert rst asynchronously mid-cycle while BUSY -> out_valid drops before the next edge and out_data=RESET_VALUE.
- With the macro defined and CNT_WIDTH=4:
  - hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15;
  - a subsequent flush leaves it at 15; rst clears it to 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Purpose  : Pipeline inter-stage register, valid/ready handshake with a
//            one-entry skid buffer and synchronous flush. Optional saturating
//            backpressure counter enabled by macro PIPE_SKID_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] stall_cnt
`else
  output logic [WIDTH-1:0]     out_data
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             r_main_v;
  logic             r_skid_v;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic       w_in_fire;
  logic       w_out_fire;
  logic [1:0] w_state;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_main_v & out_ready;
  assign w_state    = {r_skid_v, r_main_v};

  assign out_valid = r_main_v;
  assign out_data  = r_main_data;
  // Dedicated flop (always equal to !r_skid_v) keeps in_ready free of logic.
  assign in_ready  = r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_data <= RESET_VALUE;
      r_skid_data <= RESET_VALUE;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_main_data <= in_data;
            r_main_v    <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main_data <= in_data;
          end else if (w_in_fire) begin
            r_skid_data <= in_data;
            r_skid_v    <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (w_out_fire) begin
            r_main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_main_data <= r_skid_data;
            r_skid_v    <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to an empty, accepting register.
          r_main_v   <= 1'b0;
          r_skid_v   <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_v && !out_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// Testbench for pipe_skid_reg: directed scenarios plus random traffic checked
// against a queue model of the accepted-but-not-delivered words.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0),
    .CNT_WIDTH  (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef PIPE_SKID_STALL_CNT_EN
    .out_data (out_data),
    .stall_cnt(stall_cnt)
`else
    .out_data (out_data)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_q[$];
  int          m_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() > 0});
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, m_q.size() < 2});
    if (m_q.size() > 0)
      check_eq("out_data", {32'd0, out_data}, {32'd0, m_q[0]});
`ifdef PIPE_SKID_STALL_CNT_EN
    check_eq("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
`endif
  endtask

  // One clock edge: advance the model with the pre-edge handshake, then check.
  task automatic cycle();
    bit in_fire;
    bit out_fire;
    bit stalled;
    in_fire  = in_valid && (m_q.size() < 2);
    out_fire = (m_q.size() > 0) && out_ready;
    stalled  = (m_q.size() > 0) && !out_ready;
    @(posedge clk);
    if (!rst) begin
      if (stalled && m_cnt < 15) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (out_fire) void'(m_q.pop_front());
        if (in_fire) m_q.push_back(in_data);
      end
    end
    #1;
    compare_model();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_data", {32'd0, out_data}, 64'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
    check_eq("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
`endif

    // Reset release with a word already presented.
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
    cycle();
    check_eq("first_word", {32'd0, out_data}, 64'h11);
    in_valid = 1'b0;
    cycle();

    // Back-to-back stream, no bubbles.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      cycle();
      check_eq("stream_data", {32'd0, out_data}, 64'(i));
      check_eq("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure into the skid buffer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; cycle();
    in_data = 32'hB; cycle();
    check_eq("full_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("full_hold_a", {32'd0, out_data}, 64'hA);
    in_data = 32'hC; cycle();
    check_eq("full_hold_a2", {32'd0, out_data}, 64'hA);
    out_ready = 1'b1; cycle();
    check_eq("drain_b", {32'd0, out_data}, 64'hB);
    cycle();
    check_eq("drain_c", {32'd0, out_data}, 64'hC);
    in_valid = 1'b0; cycle();

    // Flush while FULL squashes the held words and the incoming one.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; cycle();
    in_data = 32'hB; cycle();
    flush = 1'b1; in_data = 32'hD; cycle();
    check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_data = 32'hE; cycle();
    check_eq("after_flush", {32'd0, out_data}, 64'hE);
    in_valid = 1'b0; out_ready = 1'b1; cycle();

    // Asynchronous reset mid-cycle while BUSY.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; cycle();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_eq("async_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("async_out_data", {32'd0, out_data}, 64'd0);
    check_eq("async_in_ready", {63'd0, in_ready}, 64'd1);
    m_q.delete(); m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturation, flush persistence, reset clear.
    in_valid = 1'b1; in_data = 32'h77; cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check_eq("cnt_sat", {60'd0, stall_cnt}, 64'd15);
    flush = 1'b1; cycle(); flush = 1'b0;
    check_eq("cnt_after_flush", {60'd0, stall_cnt}, 64'd15);
    #2 rst = 1'b1; #1;
    check_eq("cnt_rst", {60'd0, stall_cnt}, 64'd0);
    m_q.delete(); m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("final_empty", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
